// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC command queue: command field layout,
// FSM state encoding and small helpers.
package nfc_pkg;

   localparam int unsigned CMD_W   = 33;
   localparam int unsigned DIR_BIT = 32;
   localparam int unsigned FA_MSB  = 31;
   localparam int unsigned FA_LSB  = 14;
   localparam int unsigned MA_MSB  = 13;
   localparam int unsigned MA_LSB  = 7;
   localparam int unsigned LEN_MSB = 6;
   localparam int unsigned LEN_LSB = 0;
   localparam int unsigned STAT_W  = 8;

   typedef enum logic [1:0] {
      WAIT_DONE = 2'd0,
      READY     = 2'd1,
      ISSUE     = 2'd2
   } nfc_state_t;

   // Zero-length commands are filtered out before they reach the FIFO.
   function automatic logic len_is_zero(input logic [CMD_W-1:0] cmd);
      return (cmd[LEN_MSB:LEN_LSB] == '0);
   endfunction

   // Statistics counters hold at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// Synchronous command FIFO; head entry is always visible on o_dout.
// Reset clears pointers and count only; storage is left as-is.
module nfc_cmd_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned CW    = 33,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [CW-1:0]    i_din,
   output logic [CW-1:0]    o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [CW-1:0]    r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];

   assign w_wr = i_push & ~o_full;
   assign w_rd = i_pop & ~o_empty;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/nfc_cmd_queue.sv
// Command queue in front of the NAND flash controller: buffers host commands
// and issues one per NFC done, with issue/drop statistics.
module nfc_cmd_queue
   import nfc_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned CW    = CMD_W,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [CW-1:0]     i_host_cmd,
   input  logic              i_host_vld,
   output logic              o_host_rdy,
   input  logic              i_nfc_done,
   output logic [CW-1:0]     o_nfc_cmd,
   output logic              o_nfc_vld,
   output logic              o_busy,
   output logic [STAT_W-1:0] o_rd_cnt,
   output logic [STAT_W-1:0] o_wr_cnt,
   output logic [STAT_W-1:0] o_drop_cnt
);

   nfc_state_t        r_state;
   logic [CW-1:0]     r_nfc_cmd;
   logic              r_nfc_vld;
   logic              r_outstanding;
   logic              r_host_rdy;
   logic              r_busy;
   logic [STAT_W-1:0] r_rd_cnt;
   logic [STAT_W-1:0] r_wr_cnt;
   logic [STAT_W-1:0] r_drop_cnt;

   logic              w_hs;
   logic              w_zero;
   logic              w_push;
   logic              w_pop;
   logic              w_clr;
   logic              w_out_nxt;
   logic [CW-1:0]     w_head;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_cnt_nxt;

   assign w_hs   = i_host_vld & r_host_rdy;
   assign w_zero = len_is_zero(CMD_W'(i_host_cmd));
   assign w_push = w_hs & ~w_zero & ~w_full;
   assign w_pop  = (r_state == READY) & ~w_empty;
   assign w_clr  = (r_state == WAIT_DONE) & i_nfc_done;

   assign w_out_nxt = w_pop ? 1'b1 : (w_clr ? 1'b0 : r_outstanding);
   assign w_cnt_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

   nfc_cmd_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (i_host_cmd),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Issue sequencer: wait for NFC done, pop the head, pulse valid for one cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= WAIT_DONE;
         r_nfc_cmd     <= '0;
         r_nfc_vld     <= 1'b0;
         r_outstanding <= 1'b0;
         r_rd_cnt      <= '0;
         r_wr_cnt      <= '0;
      end else begin
         r_nfc_vld <= 1'b0;
         case (r_state)
            WAIT_DONE: begin
               if (i_nfc_done) begin
                  r_state       <= READY;
                  r_outstanding <= 1'b0;
               end
            end
            READY: begin
               if (!w_empty) begin
                  r_nfc_cmd     <= w_head;
                  r_nfc_vld     <= 1'b1;
                  r_outstanding <= 1'b1;
                  r_state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (r_nfc_cmd[DIR_BIT]) r_rd_cnt <= sat_inc(r_rd_cnt);
               else                    r_wr_cnt <= sat_inc(r_wr_cnt);
               r_state <= WAIT_DONE;
            end
            default: r_state <= WAIT_DONE;
         endcase
      end
   end

   // Ready and busy are registered from next-state count so they never see a same-cycle pop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_host_rdy <= 1'b1;
         r_busy     <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_host_rdy <= (w_cnt_nxt != CNT_W'(DEPTH));
         r_busy     <= (w_cnt_nxt != '0) | w_out_nxt;
         if (w_hs && w_zero) r_drop_cnt <= sat_inc(r_drop_cnt);
      end
   end

   assign o_host_rdy = r_host_rdy;
   assign o_nfc_cmd  = r_nfc_cmd;
   assign o_nfc_vld  = r_nfc_vld;
   assign o_busy     = r_busy;
   assign o_rd_cnt   = r_rd_cnt;
   assign o_wr_cnt   = r_wr_cnt;
   assign o_drop_cnt = r_drop_cnt;

endmodule
